// File: rtl/wb_semver_regbank_pkg.sv
// Shared types and helpers for the semantic-version register bank.
//  - semver_word(): packs major/minor/patch into the 32-bit version word
//  - VERSION_WORD_ADR: word address of the read-only version register
//  - wb_req_t: captured write request (address, data, byte lanes, direction)
package wb_semver_regbank_pkg;

  localparam int VERSION_WORD_ADR = 0;

  // Captured addresses are stored at the widest address the bank can use
  // (NREGS up to 255 plus the version word fits in 8 bits).
  localparam int REQ_ADR_W = 8;

  typedef struct packed {
    logic [REQ_ADR_W-1:0] adr;
    logic [31:0]          dat;
    logic [3:0]           sel;
    logic                 we;
  } wb_req_t;

  function automatic logic [31:0] semver_word(input logic [7:0] major,
                                              input logic [7:0] minor,
                                              input logic [7:0] patch);
    return {8'h00, major, minor, patch};
  endfunction

endpackage

// File: rtl/wb_semver_regbank_if.sv
// Wishbone-classic bus bundle between an interconnect master and this slave.
// Signal suffixes are from the slave's point of view.
//  master modport: drives cyc/stb/adr/sel/we/dat_i, observes ack/err/rty/stall/dat_o
//  slave  modport: the reverse
interface wb_semver_regbank_if #(
  parameter int ADR_W = 3
);
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic [ADR_W-1:0] wb_adr_i;
  logic [3:0]       wb_sel_i;
  logic             wb_we_i;
  logic [31:0]      wb_dat_i;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic             wb_rty_o;
  logic             wb_stall_o;
  logic [31:0]      wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, wb_dat_o
  );
endinterface

// File: rtl/wb_semver_regbank_tracker.sv
// Read/write-in-progress tracker for a pipelined Wishbone slave.
// Accepts a request when cyc&stb are high and nothing is in flight, and
// holds off re-acceptance until the slave's ack/err cycle has passed.
//  clk_i, rst_i : clock, synchronous active-high reset
//  cyc_i, stb_i, we_i : bus request qualifiers
//  done_i       : registered ack|err of the owning slave
//  rd_req_o     : 1-cycle pulse, read accepted this cycle
//  wr_req_o     : 1-cycle pulse, write accepted this cycle
module wb_semver_regbank_tracker (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic we_i,
  input  logic done_i,
  output logic rd_req_o,
  output logic wr_req_o
);
  logic rip_q, rip_d;
  logic wip_q, wip_d;
  logic accept;

  assign accept   = cyc_i & stb_i & ~rip_q & ~wip_q;
  assign rd_req_o = accept & ~we_i;
  assign wr_req_o = accept &  we_i;

  // A tracker clears on the edge that ends the response cycle, so the master
  // still holding stb during ack is not mistaken for a new request.
  always_comb begin
    rip_d = rip_q;
    wip_d = wip_q;
    if (done_i) begin
      rip_d = 1'b0;
      wip_d = 1'b0;
    end
    if (rd_req_o) rip_d = 1'b1;
    if (wr_req_o) wip_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rip_q <= 1'b0;
      wip_q <= 1'b0;
    end else begin
      rip_q <= rip_d;
      wip_q <= wip_d;
    end
  end
endmodule

// File: rtl/wb_semver_regbank.sv
// Wishbone-classic slave: NREGS byte-maskable RW control registers at words
// 1..NREGS plus a read-only semantic-version word at word 0.
//  clk_i, rst_i : clock, synchronous active-high reset
//  wb           : slave side of the Wishbone bundle
//  regs_o       : register i at [32*i+31:32*i]
//  wr_stb_o     : 1-cycle pulse per register, cycle after it was written
// Reads respond one cycle after acceptance; writes are captured, applied the
// next cycle and acknowledged the cycle after that.
module wb_semver_regbank
  import wb_semver_regbank_pkg::*;
#(
  parameter int          NREGS        = 4,
  parameter int          ADR_W        = 3,
  parameter int          VER_MAJOR    = 1,
  parameter int          VER_MINOR    = 2,
  parameter int          VER_PATCH    = 3,
  parameter logic [31:0] RESET_VAL    = 32'h0,
  parameter int          ERR_ON_UNMAP = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_semver_regbank_if.slave    wb,
  output logic [NREGS*32-1:0]   regs_o,
  output logic [NREGS-1:0]      wr_stb_o
);
  localparam logic [31:0] VERSION =
    semver_word(8'(VER_MAJOR), 8'(VER_MINOR), 8'(VER_PATCH));
  localparam bit ERR_EN = (ERR_ON_UNMAP != 0);

  function automatic logic is_mapped(input logic [REQ_ADR_W-1:0] a);
    return a <= REQ_ADR_W'(NREGS);
  endfunction

  logic                 rd_req, wr_req;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          dat_q, dat_d;
  wb_req_t              d0_q;
  logic                 d0_vld_q;
  logic [ADR_W-1:0]     bus_adr;
  logic [REQ_ADR_W-1:0] rd_adr;
  logic                 rd_mapped, wr_mapped, wr_vld;
  logic [31:0]          rd_data;

  wb_semver_regbank_tracker u_tracker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cyc_i   (wb.wb_cyc_i),
    .stb_i   (wb.wb_stb_i),
    .we_i    (wb.wb_we_i),
    .done_i  (ack_q | err_q),
    .rd_req_o(rd_req),
    .wr_req_o(wr_req)
  );

  assign bus_adr   = wb.wb_adr_i;
  assign rd_adr    = REQ_ADR_W'(bus_adr);
  assign rd_mapped = is_mapped(rd_adr);
  assign wr_vld    = d0_vld_q & d0_q.we;
  assign wr_mapped = is_mapped(d0_q.adr);

  // Write capture stage: the request is applied one cycle after acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d0_vld_q <= 1'b0;
      d0_q     <= '0;
    end else begin
      d0_vld_q <= wr_req;
      if (wr_req) begin
        d0_q.adr <= rd_adr;
        d0_q.dat <= wb.wb_dat_i;
        d0_q.sel <= wb.wb_sel_i;
        d0_q.we  <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [31:0] reg_q;
      logic        stb_q;
      logic        hit;

      assign hit = wr_vld & (d0_q.adr == REQ_ADR_W'(gi + 1));

      // sel=0 still counts as a write: the strobe pulses, no byte changes.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          reg_q <= RESET_VAL;
          stb_q <= 1'b0;
        end else begin
          stb_q <= hit;
          for (int k = 0; k < 4; k++) begin
            if (hit && d0_q.sel[k]) reg_q[8*k +: 8] <= d0_q.dat[8*k +: 8];
          end
        end
      end

      assign regs_o[32*gi +: 32] = reg_q;
      assign wr_stb_o[gi]        = stb_q;
    end
  endgenerate

  // Read mux; unmapped words read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_adr == REQ_ADR_W'(VERSION_WORD_ADR)) rd_data = VERSION;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_adr == REQ_ADR_W'(i + 1)) rd_data = regs_o[32*i +: 32];
    end
  end

  // Reads and write completions cannot coincide: the tracker blocks any
  // acceptance while a write sits in the capture stage.
  always_comb begin
    ack_d = (rd_req & (rd_mapped | ~ERR_EN)) | (wr_vld & (wr_mapped | ~ERR_EN));
    err_d = ERR_EN & ((rd_req & ~rd_mapped) | (wr_vld & ~wr_mapped));
    dat_d = rd_req ? rd_data : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_rty_o   = 1'b0;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = wb.wb_cyc_i & wb.wb_stb_i & ~(ack_q | err_q);
endmodule
